// File: rtl/loopback_rx_checker_if.sv
// Receive word stream feeding the loopback checker.
//
// Handshake: there is no ready. The sink accepts a beat on every cycle
// where rx_valid is high. rx_data, rx_eof and rx_bad_frame mean something
// only when rx_valid is high, and rx_bad_frame is read only on the eof beat.
// rx_overrun is an unqualified pulse that may arrive on any cycle.
interface loopback_rx_checker_if #(
    parameter int DATA_WIDTH = 64
);
    logic                  rx_valid;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_eof;
    logic                  rx_bad_frame;
    logic                  rx_overrun;

    modport master (
        output rx_valid,
        output rx_data,
        output rx_eof,
        output rx_bad_frame,
        output rx_overrun
    );

    modport slave (
        input rx_valid,
        input rx_data,
        input rx_eof,
        input rx_bad_frame,
        input rx_overrun
    );
endinterface

// File: rtl/loopback_rx_checker.sv
// Receive-side loopback checker (user_clk domain).
// Frames the incoming beats into packets, checks each packet's header
// sequence number, length and MAC frame status, and counts good and
// errored packets. Status flags are sticky until cnt_clr or reset.
module loopback_rx_checker #(
    parameter int DATA_WIDTH = 64,
    parameter int CNT_WIDTH  = 32,
    parameter int PKT_LEN    = 128,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  user_clk,
    input  logic                  user_rst,
    input  logic                  cnt_clr,
    loopback_rx_checker_if.slave  rx,
    output logic [CNT_WIDTH-1:0]  rx_cnt,
    output logic [CNT_WIDTH-1:0]  err_cnt,
    output logic [3:0]            status,
    output logic [31:0]           cur_seq,
    output logic [1:0]            dbg_state_o
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_DROP    = 2'd2
    } state_t;

    // The beat counter stops one above the legal length so that an
    // over-long packet can never wrap back to a "correct" count.
    localparam logic [LEN_WIDTH-1:0] LEN_OK  = LEN_WIDTH'(PKT_LEN);
    localparam logic [LEN_WIDTH-1:0] LEN_SAT = LEN_WIDTH'(PKT_LEN + 1);
    localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    // Status bit positions: {overrun, len_err, seq_err, bad_frame}.
    localparam int ST_OVR = 3;
    localparam int ST_LEN = 2;
    localparam int ST_SEQ = 1;
    localparam int ST_BAD = 0;

    state_t                 state_q, state_d;
    logic [LEN_WIDTH-1:0]   beats_q, beats_d;
    logic [31:0]            hdr_seq_q, hdr_seq_d;
    logic [31:0]            cur_seq_q, cur_seq_d;
    logic [CNT_WIDTH-1:0]   rx_cnt_q, rx_cnt_d;
    logic [CNT_WIDTH-1:0]   err_cnt_q, err_cnt_d;
    logic [3:0]             status_q, status_d;

    logic [DATA_WIDTH-1:0]  rx_data_w;
    logic [31:0]            hdr_w;
    logic                   eof_beat;
    logic [LEN_WIDTH-1:0]   beats_inc;

    // Completion bookkeeping produced by the FSM for the counter logic.
    logic                   done;
    logic                   drop_done;
    logic [LEN_WIDTH-1:0]   chk_beats;
    logic [31:0]            chk_seq;
    logic                   len_bad;
    logic                   seq_bad;
    logic                   frm_bad;

    assign rx_data_w = rx.rx_data;
    assign hdr_w     = rx_data_w[31:0];
    assign eof_beat  = rx.rx_valid & rx.rx_eof;
    assign beats_inc = (beats_q >= LEN_SAT) ? beats_q : beats_q + LEN_ONE;

    // Only the low word of the header beat carries information here.
    generate
        if (DATA_WIDTH > 32) begin : g_unused_hi
            logic unused_data_hi;
            assign unused_data_hi = ^rx_data_w[DATA_WIDTH-1:32];
        end
    endgenerate

    // State, counters and flags register; async reset clears everything.
    always_ff @(posedge user_clk or posedge user_rst) begin
        if (user_rst) begin
            state_q   <= ST_IDLE;
            beats_q   <= '0;
            hdr_seq_q <= '0;
            cur_seq_q <= '0;
            rx_cnt_q  <= '0;
            err_cnt_q <= '0;
            status_q  <= '0;
        end else begin
            state_q   <= state_d;
            beats_q   <= beats_d;
            hdr_seq_q <= hdr_seq_d;
            cur_seq_q <= cur_seq_d;
            rx_cnt_q  <= rx_cnt_d;
            err_cnt_q <= err_cnt_d;
            status_q  <= status_d;
        end
    end

    // Packet framing FSM plus completion checks and saturating counters.
    always_comb begin
        state_d   = state_q;
        beats_d   = beats_q;
        hdr_seq_d = hdr_seq_q;
        cur_seq_d = cur_seq_q;
        rx_cnt_d  = rx_cnt_q;
        err_cnt_d = err_cnt_q;
        status_d  = status_q;
        done      = 1'b0;
        drop_done = 1'b0;
        chk_beats = beats_q;
        chk_seq   = hdr_seq_q;
        len_bad   = 1'b0;
        seq_bad   = 1'b0;
        frm_bad   = 1'b0;

        // Overrun is recorded whatever the framing state.
        if (rx.rx_overrun) begin
            status_d[ST_OVR] = 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (rx.rx_valid) begin
                    hdr_seq_d = hdr_w;
                    beats_d   = LEN_ONE;
                    if (rx.rx_eof) begin
                        // Single-beat packet: header is also the last beat.
                        done      = 1'b1;
                        chk_beats = LEN_ONE;
                        chk_seq   = hdr_w;
                    end else if (rx.rx_overrun) begin
                        state_d = ST_DROP;
                    end else begin
                        state_d = ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (rx.rx_valid) begin
                    beats_d = beats_inc;
                end
                if (rx.rx_overrun) begin
                    // A packet hit by an overrun cannot be trusted, even
                    // when the overrun coincides with its last beat.
                    if (eof_beat) begin
                        drop_done = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        state_d   = ST_DROP;
                    end
                end else if (eof_beat) begin
                    done      = 1'b1;
                    chk_beats = beats_inc;
                    chk_seq   = hdr_seq_q;
                    state_d   = ST_IDLE;
                end
            end
            ST_DROP: begin
                if (eof_beat) begin
                    drop_done = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (done) begin
            len_bad   = (chk_beats != LEN_OK);
            seq_bad   = (chk_seq != cur_seq_q);
            frm_bad   = rx.rx_bad_frame;
            beats_d   = '0;
            // Resync to the received header so one lost packet costs one error.
            cur_seq_d = chk_seq + 32'd1;
            if (len_bad || seq_bad || frm_bad) begin
                if (err_cnt_q != '1) begin
                    err_cnt_d = err_cnt_q + CNT_ONE;
                end
                if (len_bad) status_d[ST_LEN] = 1'b1;
                if (seq_bad) status_d[ST_SEQ] = 1'b1;
                if (frm_bad) status_d[ST_BAD] = 1'b1;
            end else if (rx_cnt_q != '1) begin
                rx_cnt_d = rx_cnt_q + CNT_ONE;
            end
        end

        if (drop_done) begin
            beats_d = '0;
            if (err_cnt_q != '1) begin
                err_cnt_d = err_cnt_q + CNT_ONE;
            end
        end

        // Software clear wins over everything, including a coincident
        // eof beat and an overrun pulse.
        if (cnt_clr) begin
            state_d   = ST_IDLE;
            beats_d   = '0;
            hdr_seq_d = '0;
            cur_seq_d = '0;
            rx_cnt_d  = '0;
            err_cnt_d = '0;
            status_d  = '0;
        end
    end

    assign rx_cnt      = rx_cnt_q;
    assign err_cnt     = err_cnt_q;
    assign status      = status_q;
    assign cur_seq     = cur_seq_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_loopback_rx_checker.sv
// Directed bench for loopback_rx_checker. A main instance (32-bit counters,
// 128-beat packets) is checked through an expected-value queue popped by a
// monitor after every eof beat; a small instance (4-bit counters, 4-beat
// packets, 3-bit beat counter) exercises counter and beat saturation.
module tb_loopback_rx_checker;

    localparam int DW = 64;

    logic user_clk = 1'b0;
    logic user_rst = 1'b1;
    logic cnt_clr  = 1'b0;
    logic sm_clr   = 1'b0;

    always #5 user_clk = ~user_clk;

    loopback_rx_checker_if #(.DATA_WIDTH(DW)) rx_if ();
    loopback_rx_checker_if #(.DATA_WIDTH(DW)) sm_if ();

    logic [31:0] rx_cnt, err_cnt, cur_seq;
    logic [3:0]  status;
    logic [1:0]  dbg_state;

    logic [3:0]  sm_rx_cnt, sm_err_cnt, sm_status;
    logic [31:0] sm_cur_seq;
    logic [1:0]  sm_dbg_state;

    loopback_rx_checker #(
        .DATA_WIDTH(DW), .CNT_WIDTH(32), .PKT_LEN(128), .LEN_WIDTH(16)
    ) dut (
        .user_clk(user_clk), .user_rst(user_rst), .cnt_clr(cnt_clr),
        .rx(rx_if), .rx_cnt(rx_cnt), .err_cnt(err_cnt), .status(status),
        .cur_seq(cur_seq), .dbg_state_o(dbg_state)
    );

    loopback_rx_checker #(
        .DATA_WIDTH(DW), .CNT_WIDTH(4), .PKT_LEN(4), .LEN_WIDTH(3)
    ) dut_sm (
        .user_clk(user_clk), .user_rst(user_rst), .cnt_clr(sm_clr),
        .rx(sm_if), .rx_cnt(sm_rx_cnt), .err_cnt(sm_err_cnt), .status(sm_status),
        .cur_seq(sm_cur_seq), .dbg_state_o(sm_dbg_state)
    );

    // Expected {rx_cnt, err_cnt, status, cur_seq} after each eof beat.
    logic [99:0] exp_q[$];
    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    logic eof_seen = 1'b0;
    always @(posedge user_clk) eof_seen <= rx_if.rx_valid & rx_if.rx_eof;

    always @(negedge user_clk) begin
        logic [99:0] e;
        if (eof_seen) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL sb_empty: eof seen with no expected entry");
            end else begin
                e = exp_q.pop_front();
                check("pkt_rx_cnt",  rx_cnt,          e[99:68]);
                check("pkt_err_cnt", err_cnt,         e[67:36]);
                check("pkt_status",  {28'd0, status}, {28'd0, e[35:32]});
                check("pkt_cur_seq", cur_seq,         e[31:0]);
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic beat(input logic v, input logic [31:0] lo, input logic eof,
                        input logic bad, input logic ovr, input logic clr);
        @(negedge user_clk);
        rx_if.rx_valid     = v;
        rx_if.rx_data      = {32'hDEADBEEF, lo};
        rx_if.rx_eof       = eof;
        rx_if.rx_bad_frame = bad;
        rx_if.rx_overrun   = ovr;
        cnt_clr            = clr;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) beat(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic send_pkt(input logic [31:0] seq, input int n, input logic bad,
                            input int ovr_at, input logic clr_eof,
                            input logic [31:0] e_rx, input logic [31:0] e_err,
                            input logic [3:0] e_st, input logic [31:0] e_seq);
        for (int i = 0; i < n; i++) begin
            logic eof;
            eof = (i == n - 1);
            if (eof) exp_q.push_back({e_rx, e_err, e_st, e_seq});
            beat(1'b1, (i == 0) ? seq : i, eof, eof & bad, i == ovr_at, eof & clr_eof);
        end
    endtask

    task automatic clr_pulse();
        beat(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(1);
    endtask

    task automatic sm_pkt(input logic [31:0] seq, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge user_clk);
            sm_if.rx_valid     = 1'b1;
            sm_if.rx_data      = {32'h0BADF00D, (i == 0) ? seq : i};
            sm_if.rx_eof       = (i == n - 1);
            sm_if.rx_bad_frame = 1'b0;
            sm_if.rx_overrun   = 1'b0;
        end
        @(negedge user_clk);
        sm_if.rx_valid = 1'b0;
        sm_if.rx_eof   = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rx_if.rx_valid = 1'b0; rx_if.rx_data = '0; rx_if.rx_eof = 1'b0;
        rx_if.rx_bad_frame = 1'b0; rx_if.rx_overrun = 1'b0;
        sm_if.rx_valid = 1'b0; sm_if.rx_data = '0; sm_if.rx_eof = 1'b0;
        sm_if.rx_bad_frame = 1'b0; sm_if.rx_overrun = 1'b0;

        repeat (3) @(negedge user_clk);
        user_rst = 1'b0;
        @(negedge user_clk);
        check("rst_rx_cnt",  rx_cnt,  32'd0);
        check("rst_err_cnt", err_cnt, 32'd0);
        check("rst_status",  {28'd0, status}, 32'd0);
        check("rst_cur_seq", cur_seq, 32'd0);
        check("rst_state",   {30'd0, dbg_state}, 32'd0);

        // Three clean back-to-back packets.
        send_pkt(32'd0, 128, 1'b0, -1, 1'b0, 32'd1, 32'd0, 4'b0000, 32'd1);
        send_pkt(32'd1, 128, 1'b0, -1, 1'b0, 32'd2, 32'd0, 4'b0000, 32'd2);
        send_pkt(32'd2, 128, 1'b0, -1, 1'b0, 32'd3, 32'd0, 4'b0000, 32'd3);

        clr_pulse();
        check("clr_rx_cnt",  rx_cnt,  32'd0);
        check("clr_err_cnt", err_cnt, 32'd0);
        check("clr_cur_seq", cur_seq, 32'd0);

        // Sequence gap, then resynced packet is good.
        send_pkt(32'd5, 128, 1'b0, -1, 1'b0, 32'd0, 32'd1, 4'b0010, 32'd6);
        send_pkt(32'd6, 128, 1'b0, -1, 1'b0, 32'd1, 32'd1, 4'b0010, 32'd7);

        // Short packet with bad frame: one error, two flags.
        clr_pulse();
        send_pkt(32'd0, 127, 1'b1, -1, 1'b0, 32'd0, 32'd1, 4'b0101, 32'd1);

        // Overrun at beat 40: dropped, cur_seq untouched.
        send_pkt(32'd1, 128, 1'b0, 39, 1'b0, 32'd0, 32'd2, 4'b1101, 32'd1);

        // Seven good packets, then cnt_clr on the eof of the eighth.
        clr_pulse();
        for (int k = 0; k < 7; k++)
            send_pkt(k, 128, 1'b0, -1, 1'b0, k + 1, 32'd0, 4'b0000, k + 1);
        send_pkt(32'd7, 128, 1'b0, -1, 1'b1, 32'd0, 32'd0, 4'b0000, 32'd0);

        // Sequence wrap.
        send_pkt(32'hFFFFFFFE, 128, 1'b0, -1, 1'b0, 32'd0, 32'd1, 4'b0010, 32'hFFFFFFFF);
        send_pkt(32'hFFFFFFFF, 128, 1'b0, -1, 1'b0, 32'd1, 32'd1, 4'b0010, 32'd0);

        // Single-beat packet: too short.
        send_pkt(32'd0, 1, 1'b0, -1, 1'b0, 32'd1, 32'd2, 4'b0110, 32'd1);

        // Unqualified eof/bad_frame ignored; overrun in IDLE sets the flag.
        beat(1'b0, 32'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(1);
        check("noval_rx_cnt",  rx_cnt,  32'd1);
        check("noval_err_cnt", err_cnt, 32'd2);
        beat(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(1);
        check("idle_ovr_status", {28'd0, status}, 32'h0000000E);
        beat(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(1);
        check("clr_ovr_status", {28'd0, status}, 32'd0);
        check("clr_ovr_rx_cnt", rx_cnt, 32'd0);

        // Reset in mid-packet.
        send_pkt(32'd0, 128, 1'b0, -1, 1'b0, 32'd1, 32'd0, 4'b0000, 32'd1);
        for (int i = 0; i < 60; i++)
            beat(1'b1, (i == 0) ? 32'd1 : i, 1'b0, 1'b0, i == 30, 1'b0);
        @(negedge user_clk);
        rx_if.rx_valid = 1'b0;
        rx_if.rx_overrun = 1'b0;
        user_rst = 1'b1;
        #1;
        check("arst_rx_cnt",  rx_cnt,  32'd0);
        check("arst_status",  {28'd0, status}, 32'd0);
        check("arst_cur_seq", cur_seq, 32'd0);
        check("arst_state",   {30'd0, dbg_state}, 32'd0);
        @(negedge user_clk);
        user_rst = 1'b0;
        send_pkt(32'd60, 68, 1'b0, -1, 1'b0, 32'd0, 32'd1, 4'b0110, 32'd61);
        idle(3);

        n_checks++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL sb_drain: %0d entries left, expected 0", exp_q.size());
        end

        // Small instance: counter and beat-counter saturation.
        for (int k = 0; k < 15; k++) sm_pkt(k, 4);
        check("sm_rx_15", {28'd0, sm_rx_cnt}, 32'hF);
        sm_pkt(32'd15, 4);
        sm_pkt(32'd16, 4);
        check("sm_rx_sat",  {28'd0, sm_rx_cnt},  32'hF);
        check("sm_err_0",   {28'd0, sm_err_cnt}, 32'd0);
        sm_pkt(32'd17, 12);
        check("sm_long_err",    {28'd0, sm_err_cnt}, 32'd1);
        check("sm_long_status", {28'd0, sm_status},  32'd4);
        check("sm_long_seq",    sm_cur_seq,          32'd18);
        for (int k = 18; k < 34; k++) sm_pkt(k, 12);
        check("sm_err_sat",   {28'd0, sm_err_cnt}, 32'hF);
        check("sm_rx_hold",   {28'd0, sm_rx_cnt},  32'hF);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
